// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port asynchronous SRAM between instruction
// fetch (IF) and the MEM pipeline stage. Only one access is in flight at a time.
// Arbitration happens only in IDLE. MEM requests win over fetch, except that
// fetch wins right after a MEM access, so neither side can starve the other.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_ready) and address
//   if_ready/if_data         one-cycle fetch completion strobe and instruction
//   mem_rwe/mem_addr         MEM-stage access code and data address
//   mem_wdata                store data
//   mem_ready/mem_rdata      one-cycle data completion strobe and load data
//   stall_if, stall_mem      pipeline hold requests (combinational)
//   ram_*                    SRAM address/data and active-low strobes
//
// mem_rwe encoding: 00 idle, 01 read memory, 10 write memory, 11 write
// register. Only 01 and 10 are memory requests.

module mem_arbiter #(
    parameter int WAIT_CYCLES = 0   // extra SRAM wait cycles, 0..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ready,
    output logic [15:0] if_data,
    input  logic [1:0]  mem_rwe,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic        mem_ready,
    output logic [15:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    localparam logic [1:0] RWE_READ_MEM  = 2'b01;
    localparam logic [1:0] RWE_WRITE_MEM = 2'b10;

    // Counter value on the last cycle of a read phase or write pulse.
    localparam logic [2:0] C_LAST = 3'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_RD,
        S_MEM_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_DONE_IF,
        S_DONE_MEM
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_last_mem;    // last completed access was a MEM access
    logic        r_if_ready;
    logic        r_mem_ready;
    logic [15:0] r_if_data;
    logic [15:0] r_mem_rdata;
    logic [15:0] r_ram_addr;
    logic [15:0] r_ram_wdata;
    logic        r_ram_en_n;
    logic        r_ram_oe_n;
    logic        r_ram_we_n;

    logic        w_mem_pend;
    logic        w_grant_mem;

    assign w_mem_pend  = (mem_rwe == RWE_READ_MEM) || (mem_rwe == RWE_WRITE_MEM);
    // Fetch takes its turn after a MEM access if it is waiting.
    assign w_grant_mem = w_mem_pend && !(r_last_mem && if_req);

    // Address and write data are captured into the SRAM-facing registers at
    // grant, so requester changes after grant cannot disturb the access.
    // NOTE: every register here, data outputs included, is async-reset so that
    // an aborted access drops its SRAM strobes at once and outputs start known.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_mem  <= 1'b0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_en_n  <= 1'b1;
            r_ram_oe_n  <= 1'b1;
            r_ram_we_n  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge state and registers update together.
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_mem) begin
                        r_ram_addr <= mem_addr;
                        r_ram_en_n <= 1'b0;
                        if (mem_rwe == RWE_READ_MEM) begin
                            r_ram_oe_n <= 1'b0;
                            r_state    <= S_MEM_RD;
                        end else begin
                            r_ram_wdata <= mem_wdata;
                            r_state     <= S_WR_SETUP;
                        end
                    end else if (if_req) begin
                        r_ram_addr <= if_addr;
                        r_ram_en_n <= 1'b0;
                        r_ram_oe_n <= 1'b0;
                        r_state    <= S_IF_RD;
                    end
                end

                S_IF_RD, S_MEM_RD: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt      <= '0;
                        r_ram_en_n <= 1'b1;
                        r_ram_oe_n <= 1'b1;
                        if (r_state == S_IF_RD) begin
                            r_if_data  <= ram_rdata;
                            r_if_ready <= 1'b1;
                            r_state    <= S_DONE_IF;
                        end else begin
                            r_mem_rdata <= ram_rdata;
                            r_mem_ready <= 1'b1;
                            r_state     <= S_DONE_MEM;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                // One cycle of address/data setup before the write strobe.
                S_WR_SETUP: begin
                    r_ram_we_n <= 1'b0;
                    r_state    <= S_WR_PULSE;
                end

                S_WR_PULSE: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt       <= '0;
                        r_ram_we_n  <= 1'b1;
                        r_ram_en_n  <= 1'b1;
                        r_mem_ready <= 1'b1;
                        r_state     <= S_DONE_MEM;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                S_DONE_IF: begin
                    r_if_ready <= 1'b0;
                    r_last_mem <= 1'b0;
                    r_state    <= S_IDLE;
                end

                S_DONE_MEM: begin
                    r_mem_ready <= 1'b0;
                    r_last_mem  <= 1'b1;
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_ram_en_n <= 1'b1;
                    r_ram_oe_n <= 1'b1;
                    r_ram_we_n <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ready  = r_if_ready;
    assign if_data   = r_if_data;
    assign mem_ready = r_mem_ready;
    assign mem_rdata = r_mem_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_en_n  = r_ram_en_n;
    assign ram_oe_n  = r_ram_oe_n;
    assign ram_we_n  = r_ram_we_n;

    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = w_mem_pend & ~r_mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=0 backed by
// an SRAM model, one with WAIT_CYCLES=3 backed by an address-pattern source.

module tb_mem_arbiter;

    localparam logic [1:0] RWE_IDLE      = 2'b00;
    localparam logic [1:0] RWE_READ_MEM  = 2'b01;
    localparam logic [1:0] RWE_WRITE_MEM = 2'b10;
    localparam logic [1:0] RWE_WRITE_REG = 2'b11;

    logic        clk;
    logic        rst;

    // WAIT_CYCLES = 0 instance
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ready;
    logic [15:0] if_data;
    logic [1:0]  mem_rwe;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_en_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    // WAIT_CYCLES = 3 instance
    logic        if_req_3;
    logic [15:0] if_addr_3;
    logic        if_ready_3;
    logic [15:0] if_data_3;
    logic [1:0]  mem_rwe_3;
    logic [15:0] mem_addr_3;
    logic [15:0] mem_wdata_3;
    logic        mem_ready_3;
    logic [15:0] mem_rdata_3;
    logic        stall_if_3;
    logic        stall_mem_3;
    logic [15:0] ram_addr_3;
    logic [15:0] ram_wdata_3;
    logic [15:0] ram_rdata_3;
    logic        ram_en_n_3;
    logic        ram_oe_n_3;
    logic        ram_we_n_3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sram [0:65535];

    mem_arbiter #(.WAIT_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .mem_rwe(mem_rwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    mem_arbiter #(.WAIT_CYCLES(3)) u_dut_3 (
        .clk(clk), .rst(rst),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_ready(if_ready_3), .if_data(if_data_3),
        .mem_rwe(mem_rwe_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_ready(mem_ready_3), .mem_rdata(mem_rdata_3),
        .stall_if(stall_if_3), .stall_mem(stall_mem_3),
        .ram_addr(ram_addr_3), .ram_wdata(ram_wdata_3), .ram_rdata(ram_rdata_3),
        .ram_en_n(ram_en_n_3), .ram_oe_n(ram_oe_n_3), .ram_we_n(ram_we_n_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: preloaded while reset is low, written on any clock edge
    // that sees the chip and write enables both low.
    always @(posedge clk) begin
        if (!rst) begin
            sram[16'h0010] <= 16'h4A05;
            sram[16'h0020] <= 16'h1111;
            sram[16'h8000] <= 16'h1234;
        end else if (!ram_en_n && !ram_we_n) begin
            sram[ram_addr] <= ram_wdata;
        end
    end

    assign ram_rdata   = (!ram_en_n && !ram_oe_n) ? sram[ram_addr] : 16'hDEAD;
    assign ram_rdata_3 = (!ram_en_n_3 && !ram_oe_n_3) ? (ram_addr_3 ^ 16'hA5A5) : 16'h0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {en_n, oe_n, we_n}
    function automatic logic [2:0] strobes();
        return {ram_en_n, ram_oe_n, ram_we_n};
    endfunction

    initial begin
        rst         = 1'b0;
        if_req      = 1'b0;
        if_addr     = '0;
        mem_rwe     = RWE_IDLE;
        mem_addr    = '0;
        mem_wdata   = '0;
        if_req_3    = 1'b0;
        if_addr_3   = '0;
        mem_rwe_3   = RWE_IDLE;
        mem_addr_3  = '0;
        mem_wdata_3 = '0;
        tick();
        tick();

        // Reset state
        check("rst_ready",   {30'd0, if_ready, mem_ready}, 32'd0);
        check("rst_if_data", {16'd0, if_data}, 32'h0000);
        check("rst_mem_rd",  {16'd0, mem_rdata}, 32'h0000);
        check("rst_strobes", {29'd0, strobes()}, 32'h7);
        check("rst_addr",    {ram_addr, ram_wdata}, 32'h0);
        check("rst_strb_3",  {29'd0, ram_en_n_3, ram_oe_n_3, ram_we_n_3}, 32'h7);
        rst = 1'b1;
        tick();

        // Fetch at 0x0010
        if_req  = 1'b1;
        if_addr = 16'h0010;
        #1;
        check("fetch_stall_req", {31'd0, stall_if}, 32'd1);
        tick();
        check("fetch_rd_strb", {29'd0, strobes()}, 32'h1);
        check("fetch_rd_addr", {16'd0, ram_addr}, 32'h0010);
        check("fetch_rd_stall", {30'd0, stall_if, if_ready}, 32'h2);
        tick();
        check("fetch_ready", {31'd0, if_ready}, 32'd1);
        check("fetch_data", {16'd0, if_data}, 32'h4A05);
        check("fetch_unstall", {31'd0, stall_if}, 32'd0);
        check("fetch_done_strb", {29'd0, strobes()}, 32'h7);
        if_req = 1'b0;
        tick();
        check("fetch_one_shot", {31'd0, if_ready}, 32'd0);
        check("fetch_hold", {16'd0, if_data}, 32'h4A05);

        // Load and fetch collide; last served was IF, so MEM wins
        mem_rwe  = RWE_READ_MEM;
        mem_addr = 16'h8000;
        if_req   = 1'b1;
        if_addr  = 16'h0020;
        #1;
        check("coll_stalls", {30'd0, stall_if, stall_mem}, 32'h3);
        tick();
        mem_addr = 16'hFFFF;     // must not disturb the granted load
        #1;
        check("coll_mem_addr", {16'd0, ram_addr}, 32'h8000);
        check("coll_mem_strb", {29'd0, strobes()}, 32'h1);
        tick();
        check("coll_mem_ready", {30'd0, mem_ready, if_ready}, 32'h2);
        check("coll_mem_data", {16'd0, mem_rdata}, 32'h1234);
        check("coll_stalls2", {30'd0, stall_if, stall_mem}, 32'h2);
        mem_addr = 16'h8000;     // next load already waiting
        tick();
        check("coll_idle", {29'd0, strobes()}, 32'h7);
        tick();
        check("coll_if_addr", {16'd0, ram_addr}, 32'h0020);
        check("coll_if_strb", {29'd0, strobes()}, 32'h1);
        tick();
        check("coll_if_ready", {30'd0, if_ready, mem_ready}, 32'h2);
        check("coll_if_data", {16'd0, if_data}, 32'h1111);
        check("coll_mem_wait", {31'd0, stall_mem}, 32'd1);
        if_req = 1'b0;
        tick();
        tick();
        check("coll_mem2_addr", {16'd0, ram_addr}, 32'h8000);
        tick();
        check("coll_mem2_ready", {31'd0, mem_ready}, 32'd1);
        mem_rwe = RWE_IDLE;
        tick();

        // Store 0xBEEF to 0x8001
        mem_rwe   = RWE_WRITE_MEM;
        mem_addr  = 16'h8001;
        mem_wdata = 16'hBEEF;
        tick();
        mem_wdata = 16'h0000;    // must not disturb the granted store
        #1;
        check("st_setup_strb", {29'd0, strobes()}, 32'h3);
        check("st_setup_bus", {ram_addr, ram_wdata}, 32'h8001BEEF);
        tick();
        check("st_pulse_strb", {29'd0, strobes()}, 32'h2);
        check("st_pulse_bus", {ram_addr, ram_wdata}, 32'h8001BEEF);
        check("st_pulse_nrdy", {31'd0, mem_ready}, 32'd0);
        tick();
        check("st_ready", {31'd0, mem_ready}, 32'd1);
        check("st_done_strb", {29'd0, strobes()}, 32'h7);
        check("st_sram", {16'd0, sram[16'h8001]}, 32'hBEEF);
        mem_rwe = RWE_IDLE;
        tick();

        // Read back 0x8001
        mem_rwe  = RWE_READ_MEM;
        tick();
        tick();
        check("rb_ready", {31'd0, mem_ready}, 32'd1);
        check("rb_data", {16'd0, mem_rdata}, 32'hBEEF);
        mem_rwe = RWE_IDLE;
        tick();
        check("rb_hold", {16'd0, mem_rdata}, 32'hBEEF);

        // WRITE_REG code is not a memory request
        mem_rwe = RWE_WRITE_REG;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wreg_quiet", {27'd0, strobes(), stall_mem, mem_ready}, 32'h1C);
        end
        mem_rwe = RWE_IDLE;
        tick();

        // Reset asserted during the write pulse
        mem_rwe   = RWE_WRITE_MEM;
        mem_addr  = 16'h8002;
        mem_wdata = 16'h5555;
        tick();
        tick();
        check("rs_in_pulse", {31'd0, ram_we_n}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("rs_we_release", {29'd0, strobes()}, 32'h7);
        check("rs_no_ready", {31'd0, mem_ready}, 32'd0);
        mem_rwe = RWE_IDLE;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_quiet", {28'd0, strobes(), mem_ready}, 32'hE);
        end

        // Normal fetch after the abort
        if_req  = 1'b1;
        if_addr = 16'h0010;
        tick();
        check("rs_fetch_strb", {29'd0, strobes()}, 32'h1);
        tick();
        check("rs_fetch_data", {15'd0, if_ready, if_data}, 32'h14A05);
        if_req = 1'b0;
        tick();

        // WAIT_CYCLES = 3 read: four cycles of output enable, ready on the fifth
        mem_rwe_3  = RWE_READ_MEM;
        mem_addr_3 = 16'h0123;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("w3_phase", {30'd0, ram_oe_n_3, mem_ready_3}, 32'h0);
        end
        tick();
        check("w3_ready", {31'd0, mem_ready_3}, 32'd1);
        check("w3_data", {16'd0, mem_rdata_3}, 32'hA486);
        check("w3_strb", {29'd0, ram_en_n_3, ram_oe_n_3, ram_we_n_3}, 32'h7);
        mem_rwe_3 = RWE_IDLE;
        tick();
        check("w3_one_shot", {31'd0, mem_ready_3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
